// File: rtl/button_debouncer.sv
// Front-panel pushbutton conditioner: 2-flop synchroniser, stable-count debounce
// filter, and registered level plus press/release/long-press strobes.
// Latency: a pin change that is stable from before edge e0 shows up after edge
// e(DEBOUNCE_CYCLES+1). There is no backpressure; the strobes are one-cycle pulses.
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   in          raw asynchronous button/switch pin
//   btn_level   debounced pressed level
//   btn_press   one-cycle strobe when a press is accepted
//   btn_release one-cycle strobe when a release is accepted
//   btn_long    one-cycle strobe when the hold time is reached (at most once per press)
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  // A zero-width counter is illegal, so a disabled hold timer still gets one bit.
  localparam int HOLD_W = (HOLD_CYCLES == 0) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam bit HOLD_EN = (HOLD_CYCLES != 0);
  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

  // A one-cycle filter would collapse into a plain synchroniser.
  if (DEBOUNCE_CYCLES < 2) begin : g_param_check
    $error("button_debouncer: DEBOUNCE_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t            state, state_nxt;
  logic              s1, s2;
  logic              p;
  logic [DEB_W-1:0]  deb_cnt, deb_cnt_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_inc;
  logic              level_nxt, press_nxt, release_nxt, hold_clear;

  // Polarity is applied before synchronisation. The sync flops then reset to the
  // not-pressed value whatever the pin polarity is.
  assign p = in ^ ACTIVE_LOW;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= p;
      s2 <= s1;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      deb_cnt     <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      state       <= state_nxt;
      deb_cnt     <= deb_cnt_nxt;
      btn_level   <= level_nxt;
      btn_press   <= press_nxt;
      btn_release <= release_nxt;
    end
  end

  // Next-state logic. deb_cnt counts consecutive samples that disagree with the
  // accepted level. Any agreeing sample drops the FSM back to its stable state.
  always_comb begin
    state_nxt   = state;
    deb_cnt_nxt = deb_cnt;
    level_nxt   = btn_level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    hold_clear  = 1'b0;
    case (state)
      IDLE: begin
        if (s2) begin
          state_nxt   = PRESS_WAIT;
          deb_cnt_nxt = DEB_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (!s2) begin
          state_nxt   = IDLE;
          deb_cnt_nxt = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt   = PRESSED;
          deb_cnt_nxt = '0;
          level_nxt   = 1'b1;
          press_nxt   = 1'b1;
          hold_clear  = 1'b1;
        end else begin
          deb_cnt_nxt = deb_cnt + DEB_W'(1);
        end
      end
      PRESSED: begin
        if (!s2) begin
          state_nxt   = RELEASE_WAIT;
          deb_cnt_nxt = DEB_W'(1);
        end
      end
      RELEASE_WAIT: begin
        // A release glitch returns to PRESSED without touching the hold timer.
        if (s2) begin
          state_nxt   = PRESSED;
          deb_cnt_nxt = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt   = IDLE;
          deb_cnt_nxt = '0;
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
        end else begin
          deb_cnt_nxt = deb_cnt + DEB_W'(1);
        end
      end
      default: begin
        state_nxt   = IDLE;
        deb_cnt_nxt = '0;
        level_nxt   = 1'b0;
      end
    endcase
  end

  assign hold_inc = hold_cnt + HOLD_W'(1);

  // The hold timer runs while the registered level is high and saturates at
  // HOLD_CYCLES. Because it saturates, btn_long can fire only once per press.
  // On the edge that accepts a release the level is still high, so the timer
  // can reach the limit on that same edge and btn_long coincides with btn_release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      btn_long <= 1'b0;
    end else if (hold_clear) begin
      hold_cnt <= '0;
      btn_long <= 1'b0;
    end else if (HOLD_EN && btn_level && (hold_cnt != HOLD_MAX)) begin
      hold_cnt <= hold_inc;
      btn_long <= (hold_inc == HOLD_MAX);
    end else begin
      btn_long <= 1'b0;
    end
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Input-side counterpart to the front-panel LED driver: conditions one raw front-panel pushbutton or switch pin into clean, clock-domain-safe status.
- Synchronises the asynchronous pin and rejects bounce with a stable-count filter.
- Produces a debounced level plus one-cycle press, release and long-press strobes for control logic such as mode select or manual trigger.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive synchronised samples needed to accept a level change. Must be >= 2; elaboration fails otherwise.
- HOLD_CYCLES, 50000000, cycles the debounced level must stay high before btn_long fires. 0 disables long-press.
- ACTIVE_LOW, 0, 1 inverts the pin (pressed = pin low) before synchronisation.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- in  input  1  raw asynchronous button/switch pin
- btn_level  output  1  debounced pressed level
- btn_press  output  1  one-cycle strobe when a press is accepted
- btn_release  output  1  one-cycle strobe when a release is accepted
- btn_long  output  1  one-cycle strobe when hold time is reached, at most once per press

Behaviour:
- Reset: one clock; rst_n is asynchronous and active-low. While rst_n=0:
  - all outputs 0;
  - FSM in IDLE;
  - sync flops hold the not-pressed value;
  - all counters 0.
- Synchroniser:
  - p = in XOR ACTIVE_LOW.
  - Two-flop chain s1 <= p, s2 <= s1. The FSM uses only s2.
  - A pin change before edge e0 is first seen by the FSM at edge e2.
- Counters:
  - deb_cnt is ceil(log2(DEBOUNCE_CYCLES+1)) bits.
  - hold_cnt is ceil(log2(HOLD_CYCLES+1)) bits, and saturates.
- FSM states:
  - IDLE (level 0): s2=1 -> PRESS_WAIT, deb_cnt=1.
  - PRESS_WAIT (level 0):
    - s2=0 -> IDLE, deb_cnt=0, no strobe.
    - s2=1 and deb_cnt==DEBOUNCE_CYCLES-1 -> PRESSED, with btn_level<=1, btn_press<=1, hold_cnt<=0.
    - otherwise deb_cnt++.
  - PRESSED (level 1): s2=0 -> RELEASE_WAIT, deb_cnt=1.
  - RELEASE_WAIT (level 1):
    - s2=1 -> PRESSED; hold_cnt is NOT cleared, because a glitch does not restart the hold.
    - s2=0 and deb_cnt==DEBOUNCE_CYCLES-1 -> IDLE, with btn_level<=0, btn_release<=1.
    - otherwise deb_cnt++.
- Hold counting:
  - While btn_level=1 (PRESSED or RELEASE_WAIT) and HOLD_CYCLES!=0, hold_cnt increments each cycle and saturates at HOLD_CYCLES.
  - btn_long<=1 for exactly the cycle in which hold_cnt reaches HOLD_CYCLES.
  - btn_long cannot fire again until a new press is accepted.
- Latency: pin stable from before edge e0 -> btn_level/btn_press change after edge e(DEBOUNCE_CYCLES+1). Release latency is identical.
- Registered outputs:
  - All outputs are registered.
  - Strobes are high for exactly one cycle.
  - btn_press and btn_release are never high in the same cycle.
  - btn_long can coincide with btn_release only if the hold is reached on the same edge the release is accepted; both then assert.
- Bounce: any opposite-level sample during a WAIT state aborts the change. The next qualifying change restarts deb_cnt from 1.
- Reset mid-operation:
  - Outputs drop immediately.
  - No btn_release is generated.
  - If the pin is still pressed after rst_n deasserts, a fresh press is detected with btn_press after the full sync + debounce latency.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, ACTIVE_LOW=0):
- Clean press: in 0->1 before edge 0 and held -> btn_level=1 and a 1-cycle btn_press after edge 5; no other strobes.
- Bounce reject: in pulses 1 for 3 cycles, then 0, repeated 5 times -> btn_level stays 0, no strobes. A following stable 1 gives btn_press 6 edges after its start.
- Long press: hold in=1 -> btn_press after edge 5, single btn_long after edge 25, no repeat through cycle 100. Release gives btn_release after 6 more edges.
- Release glitch: while pressed, in=0 for 2 cycles, then 1 -> btn_level stays 1, no btn_release, btn_long timing unchanged (edge 25).
- Reset mid-press: assert rst_n=0 at cycle 10 with in=1 -> all outputs 0 immediately. Deassert at cycle 15 -> btn_press after edge 15+5, no btn_release at any point.
- Polarity: ACTIVE_LOW=1, in idles 1 -> btn_level 0 after reset. in=0 held -> btn_press after edge 5.
